sevenseg_decode: RTL and testbench

SEVENSEG_DECODE -- requirements
Module: sevenseg_decode

---
 rtl/sevenseg_decode.sv | 177 +++++++++++++++++
 tb/tb_sevenseg_decode.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_decode.sv
// sevenseg_decode: samples a multiplexed 7-segment display pin bus and
// decodes each strobed digit back into a hex nibble. A pattern is accepted
// only after it has been seen unchanged for STABLE_CYCLES consecutive
// registered samples. Legal glyphs update the digit's nibble and valid
// flag. Illegal glyphs set a sticky per-digit error flag.
//
// Optional feature macro: SEVENSEG_DECODE_STRICT_EN
//   defined   : any set unused pin bit (11,8,7,5,2) makes the pattern illegal
//   undefined : unused pin bits are masked off before comparison and decode

module sevenseg_decode #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] seg_pins,
    input  logic [3:0]  digit_sel,
    input  logic [3:0]  err_clr,
    output logic [15:0] value,
    output logic [3:0]  dvalid,
    output logic [3:0]  derr,
    output logic        upd
);

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        HOLD
    } state_t;

    // Pin bits that carry segments a..g; the remaining bits are not wired
    // to any segment on the display.
    localparam logic [11:0] USED_MASK   = 12'h65B;
    localparam logic [11:0] UNUSED_MASK = 12'h9A4;
    localparam logic [7:0]  STABLE_C    = 8'(STABLE_CYCLES);

    logic [11:0] seg_in;
    logic [11:0] samp_seg;
    logic [3:0]  samp_sel;
    logic [11:0] prev_seg;
    logic [3:0]  prev_sel;
    state_t      state;
    logic [7:0]  cnt;

    logic [6:0]  glyph;
    logic [3:0]  nib;
    logic        glyph_ok;
    logic        legal;
    logic        changed;
    logic        sel_onehot;
    logic [7:0]  cnt_inc;
    logic        latch_now;

`ifdef SEVENSEG_DECODE_STRICT_EN
    assign seg_in = seg_pins;
`else
    assign seg_in = seg_pins & USED_MASK;
`endif

    // Gather segments into abcdefg order (a = MSB) and match the hex glyphs
    always_comb begin
        glyph    = {samp_seg[10], samp_seg[6], samp_seg[3], samp_seg[1],
                    samp_seg[0],  samp_seg[9], samp_seg[4]};
        nib      = 4'h0;
        glyph_ok = 1'b1;
        case (glyph)
            7'h7E:   nib = 4'h0;
            7'h30:   nib = 4'h1;
            7'h6D:   nib = 4'h2;
            7'h79:   nib = 4'h3;
            7'h33:   nib = 4'h4;
            7'h5B:   nib = 4'h5;
            7'h5F:   nib = 4'h6;
            7'h70:   nib = 4'h7;
            7'h7F:   nib = 4'h8;
            7'h7B:   nib = 4'h9;
            7'h77:   nib = 4'hA;
            7'h1F:   nib = 4'hB;
            7'h4E:   nib = 4'hC;
            7'h3D:   nib = 4'hD;
            7'h4F:   nib = 4'hE;
            7'h47:   nib = 4'hF;
            default: glyph_ok = 1'b0;
        endcase
    end

`ifdef SEVENSEG_DECODE_STRICT_EN
    assign legal = glyph_ok && ((samp_seg & UNUSED_MASK) == 12'h000);
`else
    assign legal = glyph_ok;
`endif

    // Stability tracking terms derived from the registered sample pair
    always_comb begin
        changed    = (samp_seg != prev_seg) || (samp_sel != prev_sel);
        sel_onehot = (samp_sel != 4'b0000) &&
                     ((samp_sel & (samp_sel - 4'd1)) == 4'b0000);
        cnt_inc    = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
        // A fresh one-hot sample counts as the first stable sample, so with
        // STABLE_CYCLES = 1 it latches on the very edge that observes it.
        if (changed) begin
            latch_now = sel_onehot && (STABLE_C <= 8'd1);
        end else begin
            latch_now = (state == TRACK) && (cnt_inc >= STABLE_C);
        end
    end

    // Input sample register and the previous-sample copy used for comparison
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            samp_seg <= '0;
            samp_sel <= '0;
            prev_seg <= '0;
            prev_sel <= '0;
        end else begin
            samp_seg <= seg_in;
            samp_sel <= digit_sel;
            prev_seg <= samp_seg;
            prev_sel <= samp_sel;
        end
    end

    // Stability FSM with the registered latch results
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            value  <= '0;
            dvalid <= '0;
            derr   <= '0;
            upd    <= 1'b0;
        end else begin
            upd <= latch_now && legal;

            // A new error on the same edge as its clear leaves the flag set
            derr <= (derr & ~err_clr) |
                    ((latch_now && !legal) ? samp_sel : 4'b0000);

            if (latch_now && legal) begin
                dvalid <= dvalid | samp_sel;
                for (int unsigned k = 0; k < 4; k++) begin
                    if (samp_sel[k]) begin
                        value[4*k +: 4] <= nib;
                    end
                end
            end

            if (changed) begin
                if (sel_onehot) begin
                    state <= latch_now ? HOLD : TRACK;
                    cnt   <= 8'd1;
                end else begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        cnt <= '0;
                    end
                    TRACK: begin
                        cnt   <= cnt_inc;
                        state <= latch_now ? HOLD : TRACK;
                    end
                    HOLD: begin
                        cnt <= cnt_inc;
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sevenseg_decode.sv
// tb_sevenseg_decode: directed scenarios plus a randomized run checked
// against a run-length reference model of the stability/decode rules.

module tb_sevenseg_decode;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] seg_pins;
    logic [3:0]  digit_sel;
    logic [3:0]  err_clr;
    logic [15:0] value;
    logic [3:0]  dvalid;
    logic [3:0]  derr;
    logic        upd;

    sevenseg_decode #(.STABLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_pins  (seg_pins),
        .digit_sel (digit_sel),
        .err_clr   (err_clr),
        .value     (value),
        .dvalid    (dvalid),
        .derr      (derr),
        .upd       (upd)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int upd_seen;

    // Segment a..g to pin bit (datasheet pin - 1), and unwired pin bits
    int pin_of [7] = '{10, 6, 3, 1, 0, 9, 4};
    int unused_pins [5] = '{11, 8, 7, 5, 2};
    logic [6:0] glyphs [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B,
                                7'h5F, 7'h70, 7'h7F, 7'h7B, 7'h77, 7'h1F,
                                7'h4E, 7'h3D, 7'h4F, 7'h47};

    // Reference model state
    logic [15:0] m_value;
    logic [3:0]  m_dvalid;
    logic [3:0]  m_derr;
    logic        m_upd;
    logic [15:0] m_last;
    int          m_run;

    function automatic logic [11:0] visible(input logic [11:0] p);
        logic [11:0] r;
        r = p;
`ifndef SEVENSEG_DECODE_STRICT_EN
        for (int i = 0; i < 5; i++) r[unused_pins[i]] = 1'b0;
`endif
        return r;
    endfunction

    // Returns the hex digit shown by the pins, or -1 if not a legal glyph
    function automatic int glyph_index(input logic [11:0] p);
        logic [6:0] code;
        for (int i = 0; i < 7; i++) code[6-i] = p[pin_of[i]];
`ifdef SEVENSEG_DECODE_STRICT_EN
        for (int i = 0; i < 5; i++) if (p[unused_pins[i]]) return -1;
`endif
        for (int g = 0; g < 16; g++) if (glyphs[g] == code) return g;
        return -1;
    endfunction

    function automatic logic [11:0] pins_of(input logic [6:0] code);
        logic [11:0] p;
        p = '0;
        for (int i = 0; i < 7; i++) p[pin_of[i]] = code[6-i];
        return p;
    endfunction

    // One clock edge of the reference: a run of S identical one-hot samples
    // is acted on at the edge after the S-th sample was registered.
    task automatic model_edge();
        int k;
        int gi;
        logic [15:0] key;
        if (!rst_n) begin
            m_value = '0; m_dvalid = '0; m_derr = '0; m_upd = 1'b0;
            m_last = '0; m_run = 1;
            return;
        end
        m_upd  = 1'b0;
        m_derr = m_derr & ~err_clr;
        if ($countones(m_last[3:0]) == 1 && m_run == S) begin
            k = 0;
            for (int i = 0; i < 4; i++) if (m_last[i]) k = i;
            gi = glyph_index(m_last[15:4]);
            if (gi >= 0) begin
                m_value[4*k +: 4] = gi[3:0];
                m_dvalid[k] = 1'b1;
                m_upd = 1'b1;
            end else begin
                m_derr[k] = 1'b1;
            end
        end
        key = {visible(seg_pins), digit_sel};
        if (key == m_last) begin
            if (m_run < 1000) m_run++;
        end else begin
            m_run  = 1;
            m_last = key;
        end
    endtask

    task automatic step(input logic [11:0] s, input logic [3:0] d,
                        input logic [3:0] c, input logic r);
        seg_pins = s; digit_sel = d; err_clr = c; rst_n = r;
        @(posedge clk);
        model_edge();
        #1;
        if (upd === 1'b1) upd_seen++;
    endtask

    task automatic do_reset();
        step(12'h000, 4'b0000, 4'b0000, 1'b0);
        step(12'h000, 4'b0000, 4'b0000, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        repeat (4) step(pins_of(7'h7F), 4'b0010, 4'b0000, 1'b1);
        step(12'h001, 4'b0100, 4'b0000, 1'b1);
        repeat (5) step(12'h001, 4'b0100, 4'b0000, 1'b1);
        step(12'h000, 4'b0000, 4'b0000, 1'b1);
        step(12'h000, 4'b0000, 4'b0000, 1'b0);
        n_total++;
        if ({value, dvalid, derr, upd} !== 25'h0) begin
            $display("FAIL reset_clear got value=%h dvalid=%b derr=%b upd=%b want all 0",
                     value, dvalid, derr, upd);
        end else n_pass++;
        // reset in the middle of tracking must abort the pending latch
        do_reset();
        repeat (3) step(pins_of(7'h30), 4'b0001, 4'b0000, 1'b1);
        step(pins_of(7'h30), 4'b0001, 4'b0000, 1'b0);
        upd_seen = 0;
        repeat (4) step(pins_of(7'h30), 4'b0001, 4'b0000, 1'b1);
        n_total++;
        if (upd_seen != 0 || dvalid !== 4'b0000) begin
            $display("FAIL reset_abort got upd_seen=%0d dvalid=%b want 0 0000", upd_seen, dvalid);
        end else n_pass++;
        step(12'h000, 4'b0000, 4'b0000, 1'b1);
        n_total++;
        if (upd !== 1'b1 || dvalid !== 4'b0001 || value[3:0] !== 4'h1) begin
            $display("FAIL reset_restart got upd=%b dvalid=%b nib=%h want 1 0001 1",
                     upd, dvalid, value[3:0]);
        end else n_pass++;
    endtask

    task automatic test_latency();
        do_reset();
        upd_seen = 0;
        repeat (4) step(12'h64B, 4'b0001, 4'b0000, 1'b1);
        n_total++;
        if (upd !== 1'b0 || dvalid !== 4'b0000) begin
            $display("FAIL latency_early got upd=%b dvalid=%b want 0 0000", upd, dvalid);
        end else n_pass++;
        step(12'h000, 4'b0000, 4'b0000, 1'b1);
        n_total++;
        if (value[3:0] !== 4'h0 || dvalid !== 4'b0001 || upd !== 1'b1) begin
            $display("FAIL latency_latch got nib=%h dvalid=%b upd=%b want 0 0001 1",
                     value[3:0], dvalid, upd);
        end else n_pass++;
        repeat (3) step(12'h000, 4'b0000, 4'b0000, 1'b1);
        n_total++;
        if (upd_seen != 1) begin
            $display("FAIL latency_pulses got %0d want 1", upd_seen);
        end else n_pass++;
    endtask

    task automatic test_short_hold();
        do_reset();
        upd_seen = 0;
        repeat (3) step(12'h048, 4'b0100, 4'b0000, 1'b1);
        repeat (6) step(12'h048, 4'b0000, 4'b0000, 1'b1);
        n_total++;
        if (upd_seen != 0 || dvalid !== 4'b0000) begin
            $display("FAIL short_hold got upd_seen=%0d dvalid=%b want 0 0000", upd_seen, dvalid);
        end else n_pass++;
    endtask

    task automatic test_long_hold();
        upd_seen = 0;
        repeat (20) step(12'h611, 4'b1000, 4'b0000, 1'b1);
        step(12'h000, 4'b0000, 4'b0000, 1'b1);
        n_total++;
        if (value !== 16'hF000 || dvalid !== 4'b1000 || upd_seen != 1) begin
            $display("FAIL long_hold got value=%h dvalid=%b upd_seen=%0d want F000 1000 1",
                     value, dvalid, upd_seen);
        end else n_pass++;
    endtask

    task automatic test_error();
        upd_seen = 0;
        repeat (4) step(12'h001, 4'b0010, 4'b0000, 1'b1);
        step(12'h000, 4'b0000, 4'b0000, 1'b1);
        n_total++;
        if (derr !== 4'b0010 || value !== 16'hF000 || dvalid !== 4'b1000) begin
            $display("FAIL error_set got derr=%b value=%h dvalid=%b want 0010 F000 1000",
                     derr, value, dvalid);
        end else n_pass++;
        repeat (4) step(12'h001, 4'b0010, 4'b0000, 1'b1);
        step(12'h000, 4'b0000, 4'b0010, 1'b1);
        n_total++;
        if (derr !== 4'b0010) begin
            $display("FAIL error_clr_race got derr=%b want 0010", derr);
        end else n_pass++;
        step(12'h000, 4'b0000, 4'b0010, 1'b1);
        n_total++;
        if (derr !== 4'b0000 || upd_seen != 0) begin
            $display("FAIL error_clear got derr=%b upd_seen=%0d want 0000 0", derr, upd_seen);
        end else n_pass++;
    endtask

    task automatic test_multihot();
        upd_seen = 0;
        repeat (10) step(12'h64B, 4'b0011, 4'b0000, 1'b1);
        step(12'h000, 4'b0000, 4'b0000, 1'b1);
        n_total++;
        if (upd_seen != 0 || dvalid !== 4'b1000 || derr !== 4'b0000 || value !== 16'hF000) begin
            $display("FAIL multihot got upd_seen=%0d dvalid=%b derr=%b value=%h want 0 1000 0000 F000",
                     upd_seen, dvalid, derr, value);
        end else n_pass++;
    endtask

    task automatic test_unused_bits();
        do_reset();
        upd_seen = 0;
        repeat (4) step(12'hE4B, 4'b0001, 4'b0000, 1'b1);
        step(12'h000, 4'b0000, 4'b0000, 1'b1);
        n_total++;
`ifdef SEVENSEG_DECODE_STRICT_EN
        if (derr !== 4'b0001 || upd_seen != 0 || dvalid !== 4'b0000) begin
            $display("FAIL unused_strict got derr=%b upd_seen=%0d dvalid=%b want 0001 0 0000",
                     derr, upd_seen, dvalid);
        end else n_pass++;
`else
        if (value[3:0] !== 4'h0 || dvalid !== 4'b0001 || upd_seen != 1 || derr !== 4'b0000) begin
            $display("FAIL unused_masked got nib=%h dvalid=%b upd_seen=%0d derr=%b want 0 0001 1 0000",
                     value[3:0], dvalid, upd_seen, derr);
        end else n_pass++;
`endif
        // toggling an unused pin mid-track
        for (int i = 0; i < 4; i++) begin
            step((i % 2 == 0) ? 12'h048 : 12'h848, 4'b0100, 4'b0000, 1'b1);
        end
        step(12'h000, 4'b0000, 4'b0000, 1'b1);
        n_total++;
`ifdef SEVENSEG_DECODE_STRICT_EN
        if (dvalid[2] !== 1'b0 || value[11:8] !== 4'h0) begin
            $display("FAIL unused_toggle got dvalid2=%b nib=%h want 0 0", dvalid[2], value[11:8]);
        end else n_pass++;
`else
        if (dvalid[2] !== 1'b1 || value[11:8] !== 4'h1) begin
            $display("FAIL unused_toggle got dvalid2=%b nib=%h want 1 1", dvalid[2], value[11:8]);
        end else n_pass++;
`endif
    endtask

    task automatic test_random();
        logic [11:0] pool [6] = '{12'h64B, 12'h048, 12'h611, 12'h001, 12'hE4B, 12'h848};
        logic [3:0]  sels [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0011};
        logic [11:0] s;
        logic [3:0]  d;
        logic [3:0]  c;
        int hold;
        do_reset();
        for (int seg = 0; seg < 120; seg++) begin
            case ($urandom_range(0, 2))
                0: s = pool[$urandom_range(0, 5)];
                1: s = pins_of(glyphs[$urandom_range(0, 15)]);
                default: s = 12'($urandom);
            endcase
            if ($urandom_range(0, 3) == 0) s[11] = 1'b1;
            d = sels[$urandom_range(0, 5)];
            hold = $urandom_range(1, 7);
            for (int h = 0; h < hold; h++) begin
                c = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
                step(s, d, c, ($urandom_range(0, 60) == 0) ? 1'b0 : 1'b1);
                n_total++;
                if ({value, dvalid, derr, upd} !== {m_value, m_dvalid, m_derr, m_upd}) begin
                    $display("FAIL random seg=%0d got value=%h dvalid=%b derr=%b upd=%b want %h %b %b %b",
                             seg, value, dvalid, derr, upd, m_value, m_dvalid, m_derr, m_upd);
                end else n_pass++;
            end
        end
    endtask

    initial begin
        seg_pins = '0; digit_sel = '0; err_clr = '0; rst_n = 1'b0;
        upd_seen = 0;
        test_reset();
        test_latency();
        test_short_hold();
        test_long_hold();
        test_error();
        test_multihot();
        test_unused_bits();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
